// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC owner and one-entry fetch buffer with bne redirect and retire count
module instruction_fetch #(
  parameter int ROM_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic [15:0] rom_addr,
  input  logic [15:0] rom_data,
  output logic [15:0] instr_out,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [9:0]  redirect_offset,
  output logic [15:0] fetch_count
);

  localparam logic [15:0] PC_MASK = 16'(ROM_DEPTH - 1);

  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic [15:0] r_ir_pc;
  logic        r_valid;
  logic [15:0] r_count;

  logic        w_accept;
  logic        w_take_redirect;
  logic        w_refill;
  logic [15:0] w_target;
  logic [15:0] w_pc_next;

  assign w_accept        = r_valid && instr_ready;
  assign w_take_redirect = redirect && r_valid;
  assign w_refill        = enable && (!r_valid || instr_ready);
  // Branch target is relative to the buffered instruction, not the prefetch pc.
  assign w_target        = (r_ir_pc + {{6{redirect_offset[9]}}, redirect_offset}) & PC_MASK;
  assign w_pc_next       = (r_pc + 16'd1) & PC_MASK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= 16'd0;
      r_ir    <= 16'd0;
      r_ir_pc <= 16'd0;
      r_valid <= 1'b0;
      r_count <= 16'd0;
    end else begin
      if (w_accept && (r_count != 16'hFFFF)) begin
        r_count <= r_count + 16'd1;
      end
      if (w_take_redirect) begin
        r_pc    <= w_target;
        r_valid <= 1'b0;
      end else if (w_refill) begin
        r_ir    <= rom_data;
        r_ir_pc <= r_pc;
        r_valid <= 1'b1;
        r_pc    <= w_pc_next;
      end else if (instr_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rom_addr    = r_pc;
  assign instr_out   = r_ir;
  assign instr_pc    = r_ir_pc;
  assign instr_valid = r_valid;
  assign fetch_count = r_count;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard bench for instruction_fetch
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [15:0] rom_addr;
  logic [15:0] rom_data;
  logic [15:0] instr_out;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [9:0]  redirect_offset;
  logic [15:0] fetch_count;

  logic [15:0] rom [16];
  logic [31:0] expq [$];
  int total = 0;
  int bad   = 0;

  instruction_fetch #(.ROM_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rom_addr(rom_addr),
    .rom_data(rom_data), .instr_out(instr_out), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .redirect(redirect),
    .redirect_offset(redirect_offset), .fetch_count(fetch_count)
  );

  assign rom_data = rom[rom_addr[3:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int pc);
    expq.push_back({rom[pc], 16'(pc)});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accept seen by the coming edge must match the next expected fetch.
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready) begin
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got %h/%h expected nothing", instr_out, instr_pc);
      end else begin
        logic [31:0] e;
        e = expq.pop_front();
        if ({instr_out, instr_pc} !== e) begin
          bad++;
          $display("FAIL sb_fetch: got %h/%h expected %h/%h", instr_out, instr_pc, e[31:16], e[15:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 16'hC000 | 16'(i * 16'h0111);
    rom[0] = 16'hA005;
    rom[1] = 16'hA403;
    rst_n = 1'b0; enable = 1'b0; instr_ready = 1'b0; redirect = 1'b0; redirect_offset = 10'd0;
    repeat (2) step();
    chk("rst_valid", instr_valid, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_count", fetch_count, 0);
    chk("rst_ir", instr_out, 0);
    chk("rst_irpc", instr_pc, 0);

    for (int i = 0; i < 16; i++) push(i);
    push(0);
    rst_n = 1'b1; enable = 1'b1; instr_ready = 1'b1;
    step();
    chk("first_valid", instr_valid, 1);
    chk("first_ir", instr_out, 16'hA005);
    chk("first_pc", instr_pc, 0);
    chk("first_addr", rom_addr, 1);
    repeat (16) step();
    chk("wrap_pc", instr_pc, 0);
    chk("wrap_valid", instr_valid, 1);
    chk("count16", fetch_count, 16);

    push(1); push(2);
    repeat (2) step();
    chk("pre_stall_pc", instr_pc, 2);
    instr_ready = 1'b0;
    repeat (3) step();
    chk("stall_ir", instr_out, 16'hC222);
    chk("stall_pc", instr_pc, 2);
    chk("stall_addr", rom_addr, 3);
    chk("stall_count", fetch_count, 18);
    instr_ready = 1'b1;
    push(3);
    step();
    chk("unstall_pc", instr_pc, 3);
    chk("unstall_count", fetch_count, 19);

    for (int i = 4; i <= 6; i++) push(i);
    repeat (3) step();
    chk("br1_src", instr_pc, 6);
    redirect = 1'b1; redirect_offset = 10'h3FD;
    step();
    chk("br1_valid", instr_valid, 0);
    chk("br1_addr", rom_addr, 3);
    chk("br1_count", fetch_count, 23);
    redirect = 1'b0;
    push(3);
    step();
    chk("br1_tgt_pc", instr_pc, 3);
    chk("br1_tgt_valid", instr_valid, 1);

    for (int i = 4; i <= 8; i++) push(i);
    repeat (5) step();
    chk("br2_src", instr_pc, 8);
    redirect = 1'b1; redirect_offset = 10'h3FF;
    step();
    chk("br2_addr", rom_addr, 7);
    redirect = 1'b0;
    push(7);
    step();
    chk("br2_tgt_pc", instr_pc, 7);

    for (int i = 8; i <= 15; i++) push(i);
    push(0); push(1);
    repeat (10) step();
    chk("br3_src", instr_pc, 1);
    redirect = 1'b1; redirect_offset = 10'h3FD;
    step();
    chk("br3_valid", instr_valid, 0);
    chk("br3_addr", rom_addr, 14);
    redirect_offset = 10'h005;
    push(14);
    step();
    chk("ign_valid", instr_valid, 1);
    chk("ign_pc", instr_pc, 14);
    chk("ign_addr", rom_addr, 15);

    redirect = 1'b0; enable = 1'b0;
    step();
    chk("dis_valid", instr_valid, 0);
    chk("dis_addr", rom_addr, 15);
    step();
    chk("dis_hold", rom_addr, 15);
    enable = 1'b1;
    push(15);
    step();
    chk("reen_pc", instr_pc, 15);
    step();
    chk("reen_wrap", instr_pc, 0);
    instr_ready = 1'b0;
    repeat (2) step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", instr_valid, 0);
    chk("arst_addr", rom_addr, 0);
    chk("arst_count", fetch_count, 0);
    chk("sb_drained", 32'(expq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
